// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types, defaults and result indexing for the systolic controller
package systolic_pkg;

  localparam int DEF_WIDTH          = 12;
  localparam int DEF_WIDTH_SUM      = 8;
  localparam int DEF_COMPUTE_CYCLES = 7;
  localparam int CNT_W              = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_RUN     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Element index of Cij (1-based) in the row-major result bus, C11 at the LSB.
  function automatic int c_idx(input int i, input int j);
    return 3 * (i - 1) + (j - 1);
  endfunction

endpackage

// File: rtl/SYSTOLIC_ARRAY.sv
// rtl/SYSTOLIC_ARRAY.sv - 3x3 output-stationary systolic multiply array with skewed edge feed
module SYSTOLIC_ARRAY
  import systolic_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int WIDTH_SUM = DEF_WIDTH_SUM
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_enable,
  input  logic [WIDTH-1:0]       i_a_row1,
  input  logic [WIDTH-1:0]       i_a_row2,
  input  logic [WIDTH-1:0]       i_a_row3,
  input  logic [WIDTH-1:0]       i_b_col1,
  input  logic [WIDTH-1:0]       i_b_col2,
  input  logic [WIDTH-1:0]       i_b_col3,
  output logic [9*WIDTH_SUM-1:0] o_c,
  output logic                   o_over
);

  localparam int EW = WIDTH / 3;

  logic [WIDTH-1:0]     w_a_rows [3];
  logic [WIDTH-1:0]     w_b_cols [3];
  logic [EW-1:0]        w_a_in   [3][3];
  logic [EW-1:0]        w_b_in   [3][3];
  logic [2*EW-1:0]      w_prod   [3][3];
  logic [WIDTH_SUM:0]   w_sum    [3][3];
  logic                 w_carry;
  logic [EW-1:0]        r_a      [3][2];
  logic [EW-1:0]        r_b      [2][3];
  logic [WIDTH_SUM-1:0] r_acc    [3][3];
  logic [2:0]           r_t;
  logic                 r_over;

  assign w_a_rows[0] = i_a_row1;
  assign w_a_rows[1] = i_a_row2;
  assign w_a_rows[2] = i_a_row3;
  assign w_b_cols[0] = i_b_col1;
  assign w_b_cols[1] = i_b_col2;
  assign w_b_cols[2] = i_b_col3;

  // Row i / column j is fed element k = t - i (resp. t - j), so PE(i,j) sees A[i][t-i-j] and B[t-i-j][j].
  always_comb begin
    w_carry = 1'b0;
    o_c     = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        w_a_in[i][j] = '0;
        w_b_in[i][j] = '0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (int'(r_t) >= i && int'(r_t) - i < 3) begin
        w_a_in[i][0] = w_a_rows[i][WIDTH-1-(int'(r_t)-i)*EW -: EW];
        w_b_in[0][i] = w_b_cols[i][WIDTH-1-(int'(r_t)-i)*EW -: EW];
      end
    end
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (j > 0) w_a_in[i][j] = r_a[i][j-1];
        if (i > 0) w_b_in[i][j] = r_b[i-1][j];
        w_prod[i][j] = {{EW{1'b0}}, w_a_in[i][j]} * {{EW{1'b0}}, w_b_in[i][j]};
        w_sum[i][j]  = {1'b0, r_acc[i][j]} + {{(WIDTH_SUM+1-2*EW){1'b0}}, w_prod[i][j]};
        w_carry      = w_carry | w_sum[i][j][WIDTH_SUM];
        o_c[c_idx(i+1, j+1)*WIDTH_SUM +: WIDTH_SUM] = r_acc[i][j];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_t    <= '0;
      r_over <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          r_acc[i][j] <= '0;
          if (j < 2) r_a[i][j] <= '0;
          if (i < 2) r_b[i][j] <= '0;
        end
      end
    end else if (i_enable) begin
      if (r_t != 3'd7) r_t <= r_t + 3'd1;
      if (w_carry) r_over <= 1'b1;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          r_acc[i][j] <= w_sum[i][j][WIDTH_SUM-1:0];
          if (j < 2) r_a[i][j] <= w_a_in[i][j];
          if (i < 2) r_b[i][j] <= w_b_in[i][j];
        end
      end
    end
  end

  assign o_over = r_over;

endmodule

// File: rtl/sa_cycle_counter.sv
// rtl/sa_cycle_counter.sv - RUN-phase cycle counter with load, increment and terminal-count flag
module sa_cycle_counter
  import systolic_pkg::*;
#(
  parameter int TC_VALUE = DEF_COMPUTE_CYCLES - 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_inc,
  output logic o_tc
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_tc = (r_count == CNT_W'(TC_VALUE));

endmodule

// File: rtl/systolic_array_ctrl.sv
// rtl/systolic_array_ctrl.sv - job sequencer: clear, run, capture and done-pulse around the systolic array
module systolic_array_ctrl
  import systolic_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int WIDTH_SUM      = DEF_WIDTH_SUM,
  parameter int COMPUTE_CYCLES = DEF_COMPUTE_CYCLES
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [3*WIDTH-1:0]     i_a_mat,
  input  logic [3*WIDTH-1:0]     i_b_mat,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [9*WIDTH_SUM-1:0] o_c_mat,
  output logic                   o_overflow,
  output logic                   o_arr_rst,
  output logic                   o_arr_enable,
  output logic [WIDTH-1:0]       o_arr_a_row1,
  output logic [WIDTH-1:0]       o_arr_a_row2,
  output logic [WIDTH-1:0]       o_arr_a_row3,
  output logic [WIDTH-1:0]       o_arr_b_coloum1,
  output logic [WIDTH-1:0]       o_arr_b_coloum2,
  output logic [WIDTH-1:0]       o_arr_b_coloum3,
  input  logic [9*WIDTH_SUM-1:0] i_arr_c,
  input  logic                   i_arr_over
);

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   w_accept;
  logic                   w_tc;
  logic                   r_ovf_sticky;
  logic                   r_overflow;
  logic                   r_arr_rst_n;
  logic [9*WIDTH_SUM-1:0] r_c_mat;
  logic [WIDTH-1:0]       r_a_row [3];
  logic [WIDTH-1:0]       r_b_col [3];

  assign w_accept = (r_state == ST_IDLE) && i_start && !i_abort;

  sa_cycle_counter #(
    .TC_VALUE (COMPUTE_CYCLES - 1)
  ) u_cycle_counter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (r_state == ST_CLEAR),
    .i_inc   (r_state == ST_RUN),
    .o_tc    (w_tc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_next_state = ST_CLEAR;
      ST_CLEAR:   w_next_state = i_abort ? ST_IDLE : ST_RUN;
      ST_RUN:     if (i_abort) w_next_state = ST_IDLE;
                  else if (w_tc) w_next_state = ST_CAPTURE;
      ST_CAPTURE: w_next_state = i_abort ? ST_IDLE : ST_DONE;
      ST_DONE:    w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy       = (r_state != ST_IDLE);
    o_done       = (r_state == ST_DONE);
    o_arr_enable = (r_state == ST_RUN);
  end

  // Array clear is registered from next-state so it reads 0 under reset and during CLEAR only.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_arr_rst_n  <= 1'b0;
      r_ovf_sticky <= 1'b0;
      r_overflow   <= 1'b0;
      r_c_mat      <= '0;
      for (int k = 0; k < 3; k++) begin
        r_a_row[k] <= '0;
        r_b_col[k] <= '0;
      end
    end else begin
      r_arr_rst_n <= (w_next_state != ST_CLEAR);
      if (w_accept) begin
        r_ovf_sticky <= 1'b0;
        for (int k = 0; k < 3; k++) begin
          r_a_row[k] <= i_a_mat[k*WIDTH +: WIDTH];
          r_b_col[k] <= i_b_mat[k*WIDTH +: WIDTH];
        end
      end
      if (r_state == ST_RUN) r_ovf_sticky <= r_ovf_sticky | i_arr_over;
      if (r_state == ST_CAPTURE && !i_abort) begin
        r_c_mat    <= i_arr_c;
        r_overflow <= r_ovf_sticky | i_arr_over;
      end
    end
  end

  assign o_arr_rst       = r_arr_rst_n;
  assign o_c_mat         = r_c_mat;
  assign o_overflow      = r_overflow;
  assign o_arr_a_row1    = r_a_row[0];
  assign o_arr_a_row2    = r_a_row[1];
  assign o_arr_a_row3    = r_a_row[2];
  assign o_arr_b_coloum1 = r_b_col[0];
  assign o_arr_b_coloum2 = r_b_col[1];
  assign o_arr_b_coloum3 = r_b_col[2];

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// tb/tb_systolic_array_ctrl.sv - directed self-checking bench for systolic_array_ctrl with a real array
module tb_systolic_array_ctrl;
  import systolic_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [35:0] a_mat;
  logic [35:0] b_mat;
  logic        busy;
  logic        done;
  logic [71:0] c_mat;
  logic        overflow;
  logic        arr_rst;
  logic        arr_en;
  logic [11:0] arr_a1, arr_a2, arr_a3;
  logic [11:0] arr_b1, arr_b2, arr_b3;
  logic [71:0] arr_c;
  logic        arr_over;

  int checks   = 0;
  int failures = 0;

  localparam logic [35:0] A_BASIC = 36'h789456123;
  localparam logic [35:0] B_BASIC = 36'h369258147;
  localparam logic [35:0] ALL_F   = 36'hFFFFFFFFF;
  localparam logic [35:0] B_IDENT = 36'h001010100;
  localparam logic [71:0] C_BASIC = {8'd150, 8'd126, 8'd102, 8'd96, 8'd81, 8'd66, 8'd42, 8'd36, 8'd30};
  localparam logic [71:0] C_F_ID  = {9{8'd15}};
  localparam logic [71:0] C_A_ID  = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};

  systolic_array_ctrl u_dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_start         (start),
    .i_abort         (abort),
    .i_a_mat         (a_mat),
    .i_b_mat         (b_mat),
    .o_busy          (busy),
    .o_done          (done),
    .o_c_mat         (c_mat),
    .o_overflow      (overflow),
    .o_arr_rst       (arr_rst),
    .o_arr_enable    (arr_en),
    .o_arr_a_row1    (arr_a1),
    .o_arr_a_row2    (arr_a2),
    .o_arr_a_row3    (arr_a3),
    .o_arr_b_coloum1 (arr_b1),
    .o_arr_b_coloum2 (arr_b2),
    .o_arr_b_coloum3 (arr_b3),
    .i_arr_c         (arr_c),
    .i_arr_over      (arr_over)
  );

  SYSTOLIC_ARRAY u_arr (
    .i_clk    (clk),
    .i_rst_n  (arr_rst),
    .i_enable (arr_en),
    .i_a_row1 (arr_a1),
    .i_a_row2 (arr_a2),
    .i_a_row3 (arr_a3),
    .i_b_col1 (arr_b1),
    .i_b_col2 (arr_b2),
    .i_b_col3 (arr_b3),
    .o_c      (arr_c),
    .o_over   (arr_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edge 0 samples START; returns the edge index at which DONE is seen and the ARR_ENABLE cycle count.
  task automatic run_job(input logic [35:0] a, input logic [35:0] b, output int lat, output int ens);
    a_mat = a;
    b_mat = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    ens = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
      if (arr_en) ens++;
    end
  endtask

  initial begin
    int lat, ens, k, n_done, idle_cnt;
    int done_at [2];

    rst_n = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    a_mat = '0;
    b_mat = '0;
    #3 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cmat", c_mat, 72'd0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_arr_rst", arr_rst, 1'b0);
    check("rst_arr_en", arr_en, 1'b0);
    check("rst_arr_a1", arr_a1, 12'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_arr_rst", arr_rst, 1'b1);

    run_job(A_BASIC, B_BASIC, lat, ens);
    check("basic_lat", lat, 9);
    check("basic_en_cycles", ens, 7);
    check("basic_cmat", c_mat, C_BASIC);
    check("basic_ovf", overflow, 1'b0);
    check("basic_b_col1", arr_b1, 12'h147);
    tick();
    check("basic_done_pulse", done, 1'b0);
    check("basic_idle_busy", busy, 1'b0);

    run_job(ALL_F, ALL_F, lat, ens);
    check("ovf_lat", lat, 9);
    check("ovf_flag", overflow, 1'b1);
    tick();
    run_job(ALL_F, B_IDENT, lat, ens);
    check("ident_cmat", c_mat, C_F_ID);
    check("ident_ovf", overflow, 1'b0);
    tick();

    a_mat = A_BASIC;
    b_mat = B_BASIC;
    start = 1'b1;
    n_done = 0;
    idle_cnt = 0;
    done_at[0] = -1;
    done_at[1] = -1;
    k = 0;
    while (n_done < 2 && k < 40) begin
      tick();
      if (n_done == 1 && !busy) idle_cnt++;
      if (done) begin
        done_at[n_done] = k;
        n_done++;
      end
      k++;
    end
    start = 1'b0;
    check("held_two_jobs", n_done, 2);
    check("held_first_done", done_at[0], 9);
    check("held_spacing", done_at[1] - done_at[0], 11);
    check("held_busy_gap", idle_cnt, 1);
    check("held_cmat", c_mat, C_BASIC);
    tick();
    tick();
    check("held_back_idle", busy, 1'b0);

    a_mat = ALL_F;
    b_mat = B_IDENT;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("abort_in_run", arr_en, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_arr_en", arr_en, 1'b0);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) n_done++;
    end
    check("abort_no_done", n_done, 0);
    check("abort_c33", c_mat[c_idx(3, 3)*8 +: 8], 8'd150);
    check("abort_cmat_kept", c_mat, C_BASIC);
    run_job(ALL_F, B_IDENT, lat, ens);
    check("post_abort_lat", lat, 9);
    check("post_abort_cmat", c_mat, C_F_ID);
    tick();

    a_mat = A_BASIC;
    b_mat = B_IDENT;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_arr_en", arr_en, 1'b0);
    check("midrst_arr_rst", arr_rst, 1'b0);
    check("midrst_cmat", c_mat, 72'd0);
    check("midrst_arr_a1", arr_a1, 12'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_job(A_BASIC, B_IDENT, lat, ens);
    check("midrst_job_lat", lat, 9);
    check("midrst_job_cmat", c_mat, C_A_ID);
    tick();

    start = 1'b1;
    abort = 1'b1;
    tick();
    check("start_abort_busy", busy, 1'b0);
    check("start_abort_no_clear", arr_rst, 1'b1);
    tick();
    check("start_abort_busy2", busy, 1'b0);
    start = 1'b0;
    abort = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
